gyro_spi_responder: RTL and testbench

SPI mode-3 peripheral that emulates the gyro PMOD's register interface from the device side. It answers the command/address/data byte protocol our gyro master FSM issues: single and auto-increment reads of angular-rate and temperature registers, plus writes to CTRL_REG1. It sits in simulation benches and loopback builds as a stand-in for the physical sensor, fed by a sample source through a `data_valid` strobe.

---
 rtl/gyro_spi_responder_pkg.sv | 51 +++++
 rtl/gyro_spi_responder_if.sv | 19 +
 rtl/gyro_spi_responder_spi_pin_sync.sv | 88 ++++++++
 rtl/gyro_spi_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_gyro_spi_responder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gyro_spi_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gyro_pkg
//  Description : Types and constants shared by the gyro SPI responder and the
//                gyro master FSM: FSM state encoding, register addresses,
//                command-byte bit positions and the responder's register
//                bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package gyro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } gyro_state_t;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_TEMP     = 6'h26;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;

    localparam int CMD_RD_BIT = 7;
    localparam int CMD_MS_BIT = 6;

    // Responder datapath registers. 'shift' holds only the seven bits already
    // received; the eighth comes straight from the synchronized mosi.
    typedef struct packed {
        logic [2:0] bit_cnt;
        logic [6:0] shift;
        logic [5:0] addr;
        logic       ms;
        logic [7:0] tx;
        logic       miso;
        logic       miso_en;
        logic       busy;
        logic       reg_wr;
        logic [5:0] reg_addr;
        logic [7:0] reg_wdata;
        logic [7:0] ctrl_reg1;
    } gyro_resp_regs_t;

    // Address of the next byte in a transaction; 6-bit arithmetic wraps
    // 0x3F -> 0x00 when auto-increment is requested.
    function automatic logic [5:0] next_addr(input logic [5:0] addr, input logic ms);
        return ms ? addr + 6'd1 : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gyro_spi_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : gyro_spi_responder_if
//  Description : SPI pin bundle between a gyro master and the responder.
//                master modport drives sclk/ss_n/mosi, slave drives
//                miso/miso_en.
//  Revision    : 1.0  initial release
// ============================================================================
interface gyro_spi_responder_if;
    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_en;

    modport master (output sclk, output ss_n, output mosi, input miso, input miso_en);
    modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_en);
endinterface
`default_nettype wire

// File: rtl/gyro_spi_responder_spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Synchronizes sclk, ss_n and mosi into clk and produces
//                registered one-cycle edge pulses. Pin-to-pulse latency is
//                SYNC_STAGES+1 cycles; o_mosi_s is delayed by the same amount
//                so it lines up with o_sclk_rise.
//  Ports       : clk, rst            - system clock, sync active-high reset
//                i_sclk/i_ss_n/i_mosi - asynchronous SPI pins
//                o_sclk_rise/fall    - sclk edge pulses
//                o_ss_fall/rise      - chip-select edge pulses
//                o_mosi_s            - aligned synchronized mosi
//  Parameters  : SYNC_STAGES (>= 2)
//  Revision    : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_sclk,
    input  wire logic i_ss_n,
    input  wire logic i_mosi,
    output logic      o_sclk_rise,
    output logic      o_sclk_fall,
    output logic      o_ss_fall,
    output logic      o_ss_rise,
    output logic      o_mosi_s
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;
    logic                   r_mosi_dly;
    logic [SYNC_STAGES:0]   r_armed;
    logic                   r_sclk_rise;
    logic                   r_sclk_fall;
    logic                   r_ss_fall;
    logic                   r_ss_rise;

    logic w_sclk_s;
    logic w_ss_s;
    logic w_armed;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    // Edges are suppressed until the chain has refilled after reset, so a
    // chip select already held low through reset is not seen as a new start.
    assign w_armed  = r_armed[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '1;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b1;
            r_ss_prev   <= 1'b1;
            r_mosi_dly  <= 1'b0;
            r_armed     <= '0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_ss_rise   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= w_sclk_s;
            r_ss_prev   <= w_ss_s;
            r_mosi_dly  <= r_mosi_sync[SYNC_STAGES-1];
            r_armed     <= {r_armed[SYNC_STAGES-1:0], 1'b1};
            r_sclk_rise <= w_armed &  w_sclk_s & ~r_sclk_prev;
            r_sclk_fall <= w_armed & ~w_sclk_s &  r_sclk_prev;
            r_ss_fall   <= w_armed & ~w_ss_s   &  r_ss_prev;
            r_ss_rise   <= w_armed &  w_ss_s   & ~r_ss_prev;
        end
    end

    assign o_sclk_rise = r_sclk_rise;
    assign o_sclk_fall = r_sclk_fall;
    assign o_ss_fall   = r_ss_fall;
    assign o_ss_rise   = r_ss_rise;
    assign o_mosi_s    = r_mosi_dly;

endmodule
`default_nettype wire

// File: rtl/gyro_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : gyro_spi_responder
//  Description : SPI mode-3 device-side model of the gyro PMOD register
//                interface. Decodes command/address/data bytes, serves
//                single and auto-increment reads of WHO_AM_I, CTRL_REG1,
//                temperature and X/Y/Z rate registers, and accepts writes
//                (only CTRL_REG1 is writable).
//  Ports       : clk, rst      - system clock, sync active-high reset
//                spi           - SPI pins (slave modport)
//                data_valid    - strobe loading x/y/z/temp_data samples
//                ctrl_reg1     - current CTRL_REG1
//                reg_wr/reg_addr/reg_wdata - write-byte pulse and its info
//                busy          - transaction in progress
//  Parameters  : WHO_AM_I_VAL, CTRL1_RST, SYNC_STAGES (>= 2)
//  Build macro : GYRO_RESP_SNAPSHOT_EN - when defined, samples are frozen
//                into a snapshot bank at the end of the command byte and all
//                reads in that transaction come from the snapshot.
//  Revision    : 1.0  initial release
// ============================================================================
module gyro_spi_responder
    import gyro_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0] CTRL1_RST    = 8'h07,
    parameter int         SYNC_STAGES  = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    gyro_spi_responder_if.slave spi,
    input  wire logic          data_valid,
    input  wire logic [15:0]   x_data,
    input  wire logic [15:0]   y_data,
    input  wire logic [15:0]   z_data,
    input  wire logic [7:0]    temp_data,
    output logic [7:0]         ctrl_reg1,
    output logic               reg_wr,
    output logic [5:0]         reg_addr,
    output logic [7:0]         reg_wdata,
    output logic               busy
);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk         (clk),
        .rst         (rst),
        .i_sclk      (spi.sclk),
        .i_ss_n      (spi.ss_n),
        .i_mosi      (spi.mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_ss_fall   (w_ss_fall),
        .o_ss_rise   (w_ss_rise),
        .o_mosi_s    (w_mosi_s)
    );

    // Live sample registers
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_z;
    logic [7:0]  r_temp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_temp <= '0;
        end else if (data_valid) begin
            r_x    <= x_data;
            r_y    <= y_data;
            r_z    <= z_data;
            r_temp <= temp_data;
        end
    end

    gyro_state_t     r_state;
    gyro_state_t     w_state_nxt;
    gyro_resp_regs_t r_dp;
    gyro_resp_regs_t w_dp_nxt;

    logic [7:0] w_byte;
    logic [5:0] w_addr_inc;

    assign w_byte     = {r_dp.shift, w_mosi_s};
    assign w_addr_inc = next_addr(r_dp.addr, r_dp.ms);

    // Sample source for bytes loaded during RD (after the command byte)
    logic [15:0] w_rd_x;
    logic [15:0] w_rd_y;
    logic [15:0] w_rd_z;
    logic [7:0]  w_rd_temp;

`ifdef GYRO_RESP_SNAPSHOT_EN
    logic [15:0] r_snap_x;
    logic [15:0] r_snap_y;
    logic [15:0] r_snap_z;
    logic [7:0]  r_snap_temp;
    logic        w_cmd_done;

    assign w_cmd_done = (r_state == ST_CMD) && w_sclk_rise && !w_ss_rise
                        && (r_dp.bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_x    <= '0;
            r_snap_y    <= '0;
            r_snap_z    <= '0;
            r_snap_temp <= '0;
        end else if (w_cmd_done) begin
            r_snap_x    <= r_x;
            r_snap_y    <= r_y;
            r_snap_z    <= r_z;
            r_snap_temp <= r_temp;
        end
    end

    assign w_rd_x    = r_snap_x;
    assign w_rd_y    = r_snap_y;
    assign w_rd_z    = r_snap_z;
    assign w_rd_temp = r_snap_temp;
`else
    assign w_rd_x    = r_x;
    assign w_rd_y    = r_y;
    assign w_rd_z    = r_z;
    assign w_rd_temp = r_temp;
`endif

    function automatic logic [7:0] f_reg_read(
        input logic [5:0]  a,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z,
        input logic [7:0]  t,
        input logic [7:0]  ctrl
    );
        logic [7:0] v;
        case (a)
            ADDR_WHO_AM_I:       v = WHO_AM_I_VAL;
            ADDR_CTRL1:          v = ctrl;
            ADDR_TEMP:           v = t;
            ADDR_OUT_X_L:        v = x[7:0];
            ADDR_OUT_X_L + 6'd1: v = x[15:8];
            ADDR_OUT_X_L + 6'd2: v = y[7:0];
            ADDR_OUT_X_L + 6'd3: v = y[15:8];
            ADDR_OUT_X_L + 6'd4: v = z[7:0];
            ADDR_OUT_X_L + 6'd5: v = z[15:8];
            default:             v = 8'h00;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= ST_IDLE;
            r_dp                <= '0;
            r_dp.ctrl_reg1      <= CTRL1_RST;
        end else begin
            r_state             <= w_state_nxt;
            r_dp                <= w_dp_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dp_nxt        = r_dp;
        w_dp_nxt.reg_wr = 1'b0;

        // Chip-select release beats everything, including a byte-completing
        // sclk edge in the same cycle: the partial byte is simply dropped.
        if (r_state != ST_IDLE && w_ss_rise) begin
            w_state_nxt      = ST_IDLE;
            w_dp_nxt.busy    = 1'b0;
            w_dp_nxt.miso_en = 1'b0;
            w_dp_nxt.miso    = 1'b0;
            w_dp_nxt.bit_cnt = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        w_state_nxt      = ST_CMD;
                        w_dp_nxt.bit_cnt = 3'd0;
                        w_dp_nxt.busy    = 1'b1;
                        w_dp_nxt.miso_en = 1'b1;
                        w_dp_nxt.miso    = 1'b0;
                    end
                end

                ST_CMD: begin
                    if (w_sclk_rise) begin
                        w_dp_nxt.shift   = w_byte[6:0];
                        w_dp_nxt.bit_cnt = r_dp.bit_cnt + 3'd1;
                        if (r_dp.bit_cnt == 3'd7) begin
                            w_dp_nxt.addr = w_byte[5:0];
                            w_dp_nxt.ms   = w_byte[CMD_MS_BIT];
                            if (w_byte[CMD_RD_BIT]) begin
                                w_state_nxt = ST_RD;
                                // Live samples here equal what the snapshot
                                // bank captures on this same edge.
                                w_dp_nxt.tx = f_reg_read(w_byte[5:0], r_x, r_y, r_z,
                                                         r_temp, r_dp.ctrl_reg1);
                            end else begin
                                w_state_nxt = ST_WR;
                            end
                        end
                    end
                end

                ST_RD: begin
                    if (w_sclk_fall) begin
                        w_dp_nxt.miso = r_dp.tx[7];
                        w_dp_nxt.tx   = {r_dp.tx[6:0], 1'b0};
                    end
                    if (w_sclk_rise) begin
                        w_dp_nxt.bit_cnt = r_dp.bit_cnt + 3'd1;
                        if (r_dp.bit_cnt == 3'd7) begin
                            w_dp_nxt.addr = w_addr_inc;
                            w_dp_nxt.tx   = f_reg_read(w_addr_inc, w_rd_x, w_rd_y, w_rd_z,
                                                       w_rd_temp, r_dp.ctrl_reg1);
                        end
                    end
                end

                ST_WR: begin
                    if (w_sclk_rise) begin
                        w_dp_nxt.shift   = w_byte[6:0];
                        w_dp_nxt.bit_cnt = r_dp.bit_cnt + 3'd1;
                        if (r_dp.bit_cnt == 3'd7) begin
                            w_dp_nxt.reg_wr    = 1'b1;
                            w_dp_nxt.reg_addr  = r_dp.addr;
                            w_dp_nxt.reg_wdata = w_byte;
                            if (r_dp.addr == ADDR_CTRL1) begin
                                w_dp_nxt.ctrl_reg1 = w_byte;
                            end
                            w_dp_nxt.addr = w_addr_inc;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign spi.miso    = r_dp.miso;
    assign spi.miso_en = r_dp.miso_en;
    assign ctrl_reg1   = r_dp.ctrl_reg1;
    assign reg_wr      = r_dp.reg_wr;
    assign reg_addr    = r_dp.reg_addr;
    assign reg_wdata   = r_dp.reg_wdata;
    assign busy        = r_dp.busy;

endmodule
`default_nettype wire

// File: tb/tb_gyro_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gyro_spi_responder
//  Description : Self-checking bench for gyro_spi_responder. A table of SPI
//                transactions is replayed with expected miso bytes queued per
//                transaction; hand-written sequences cover abort, chip-select
//                release on the final bit edge, reset mid-transaction and the
//                mid-burst sample update (GYRO_RESP_SNAPSHOT_EN aware).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gyro_spi_responder;

    localparam int HALF = 8;   // sclk half period in clk cycles

    typedef struct packed {
        logic [3:0]      nbytes;
        logic [0:6][7:0] tx;
        logic [0:6][7:0] rx;
        logic [3:0]      exp_wr;
        logic [5:0]      exp_addr;
        logic [7:0]      exp_wdata;
        logic [7:0]      exp_ctrl;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        data_valid;
    logic [15:0] x_data, y_data, z_data;
    logic [7:0]  temp_data;
    logic [7:0]  ctrl_reg1;
    logic        reg_wr;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        busy;

    gyro_spi_responder_if bus ();

    gyro_spi_responder #(
        .WHO_AM_I_VAL (8'hD3),
        .CTRL1_RST    (8'h07),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (bus.slave),
        .data_valid (data_valid),
        .x_data     (x_data),
        .y_data     (y_data),
        .z_data     (z_data),
        .temp_data  (temp_data),
        .ctrl_reg1  (ctrl_reg1),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write pulse is counted; CTRL_REG1 must reflect the write in the
    // same cycle as the pulse.
    always @(negedge clk) begin
        if (!rst && reg_wr) begin
            wr_cnt++;
            if (reg_addr == 6'h20) chk("ctrl_reg1 with reg_wr", ctrl_reg1, reg_wdata);
        end
    end

    function automatic vec_t mk(input int n, input logic [55:0] tx, input logic [55:0] rx,
                                input int wr, input logic [5:0] a, input logic [7:0] d,
                                input logic [7:0] c);
        vec_t v;
        v.nbytes    = 4'(n);
        v.tx        = tx;
        v.rx        = rx;
        v.exp_wr    = 4'(wr);
        v.exp_addr  = a;
        v.exp_wdata = d;
        v.exp_ctrl  = c;
        return v;
    endfunction

    task automatic spi_bit(input logic b, output logic r);
        @(negedge clk);
        bus.sclk = 1'b0;
        bus.mosi = b;
        repeat (HALF - 1) @(negedge clk);
        r = bus.miso;
        bus.sclk = 1'b1;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx = {rx[6:0], b};
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        bus.ss_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic load_samples(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z, input logic [7:0] t);
        @(negedge clk);
        x_data = x; y_data = y; z_data = z; temp_data = t;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic run_xfer(input int vi, input vec_t v);
        logic [7:0] r;
        logic [7:0] e;
        int         base;
        base = wr_cnt;
        for (int i = 0; i < int'(v.nbytes); i++) exp_q.push_back(v.rx[i]);
        cs_low();
        for (int i = 0; i < int'(v.nbytes); i++) begin
            spi_byte(v.tx[i], r);
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL v%0d byte%0d: got 0x%0h, expected nothing queued", vi, i, r);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("v%0d miso byte%0d", vi, i), r, e);
            end
        end
        cs_high();
        chk($sformatf("v%0d reg_wr count", vi), wr_cnt - base, v.exp_wr);
        if (v.exp_wr != 0) begin
            chk($sformatf("v%0d reg_addr", vi), reg_addr, v.exp_addr);
            chk($sformatf("v%0d reg_wdata", vi), reg_wdata, v.exp_wdata);
        end
        chk($sformatf("v%0d ctrl_reg1", vi), ctrl_reg1, v.exp_ctrl);
        chk($sformatf("v%0d busy idle", vi), busy, 1'b0);
        chk($sformatf("v%0d miso_en idle", vi), bus.miso_en, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r, r1, r2;
        logic       b;
        int         base;

        bus.sclk = 1'b1; bus.ss_n = 1'b1; bus.mosi = 1'b0;
        data_valid = 1'b0; x_data = '0; y_data = '0; z_data = '0; temp_data = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset miso", bus.miso, 1'b0);
        chk("reset miso_en", bus.miso_en, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset reg_wr", reg_wr, 1'b0);
        chk("reset reg_addr", reg_addr, 6'h00);
        chk("reset reg_wdata", reg_wdata, 8'h00);
        chk("reset ctrl_reg1", ctrl_reg1, 8'h07);

        load_samples(16'h1234, 16'h5678, 16'h9ABC, 8'h19);

        //                n  tx bytes                              expected miso bytes                                        wr addr   wdata  ctrl
        vecs[0]  = mk(2, {8'h20, 8'h0F, 40'h0},          56'h0,                                                         1, 6'h20, 8'h0F, 8'h0F);
        vecs[1]  = mk(2, {8'h8F, 48'h0},                 {8'h00, 8'hD3, 40'h0},                                         0, 6'h00, 8'h00, 8'h0F);
        vecs[2]  = mk(2, {8'hA0, 48'h0},                 {8'h00, 8'h0F, 40'h0},                                         0, 6'h00, 8'h00, 8'h0F);
        vecs[3]  = mk(7, {8'hE8, 48'h0},                 {8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A},             0, 6'h00, 8'h00, 8'h0F);
        vecs[4]  = mk(3, {8'hA6, 48'h0},                 {8'h00, 8'h19, 8'h19, 32'h0},                                  0, 6'h00, 8'h00, 8'h0F);
        vecs[5]  = mk(4, {8'hCE, 48'h0},                 {8'h00, 8'h00, 8'hD3, 8'h00, 24'h0},                           0, 6'h00, 8'h00, 8'h0F);
        vecs[6]  = mk(3, {8'h7F, 8'hAA, 8'hBB, 32'h0},   56'h0,                                                         2, 6'h00, 8'hBB, 8'h0F);
        vecs[7]  = mk(3, {8'h5F, 8'h11, 8'h3C, 32'h0},   56'h0,                                                         2, 6'h20, 8'h3C, 8'h3C);
        vecs[8]  = mk(2, {8'h0F, 8'h55, 40'h0},          56'h0,                                                         1, 6'h0F, 8'h55, 8'h3C);
        vecs[9]  = mk(3, {8'h20, 8'h01, 8'h5A, 32'h0},   56'h0,                                                         2, 6'h20, 8'h5A, 8'h5A);
        vecs[10] = mk(5, {8'hE6, 48'h0},                 {8'h00, 8'h19, 8'h00, 8'h34, 8'h12, 16'h0},                    0, 6'h00, 8'h00, 8'h5A);
        vecs[11] = mk(2, {8'hA9, 48'h0},                 {8'h00, 8'h12, 40'h0},                                         0, 6'h00, 8'h00, 8'h5A);
        vecs[12] = mk(2, {8'hA0, 48'h0},                 {8'h00, 8'h5A, 40'h0},                                         0, 6'h00, 8'h00, 8'h5A);

        for (int vi = 0; vi < 13; vi++) run_xfer(vi, vecs[vi]);

        // Abort four bits into a write data byte
        base = wr_cnt;
        cs_low();
        chk("abort busy active", busy, 1'b1);
        chk("abort miso_en active", bus.miso_en, 1'b1);
        spi_byte(8'h20, r);
        chk("abort cmd miso", r, 8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
        cs_high();
        chk("abort reg_wr count", wr_cnt - base, 0);
        chk("abort ctrl_reg1", ctrl_reg1, 8'h5A);
        chk("abort miso_en", bus.miso_en, 1'b0);
        chk("abort busy", busy, 1'b0);

        // ss_n released on the same edge as the 8th data bit's sclk rise
        base = wr_cnt;
        cs_low();
        spi_byte(8'h20, r);
        for (int i = 0; i < 7; i++) spi_bit(1'b1, b);
        @(negedge clk);
        bus.sclk = 1'b0;
        bus.mosi = 1'b1;
        repeat (HALF - 1) @(negedge clk);
        bus.sclk = 1'b1;
        bus.ss_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        chk("race reg_wr count", wr_cnt - base, 0);
        chk("race ctrl_reg1", ctrl_reg1, 8'h5A);
        chk("race busy", busy, 1'b0);

        // Reset mid-transaction; ss_n stays low, so the rest is ignored
        base = wr_cnt;
        cs_low();
        spi_byte(8'h20, r);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst busy", busy, 1'b0);
        chk("midrst miso_en", bus.miso_en, 1'b0);
        chk("midrst ctrl_reg1", ctrl_reg1, 8'h07);
        chk("midrst reg_addr", reg_addr, 6'h00);
        chk("midrst reg_wdata", reg_wdata, 8'h00);
        spi_byte(8'h20, r);
        spi_byte(8'h33, r);
        chk("midrst busy held", busy, 1'b0);
        cs_high();
        chk("midrst reg_wr count", wr_cnt - base, 0);
        chk("midrst ctrl kept", ctrl_reg1, 8'h07);
        run_xfer(13, mk(2, {8'h20, 8'h0F, 40'h0}, 56'h0, 1, 6'h20, 8'h0F, 8'h0F));

        // Samples were cleared by reset; reload and update X mid-burst
        load_samples(16'h1234, 16'h5678, 16'h9ABC, 8'h19);
        cs_low();
        spi_byte(8'hE8, r);
        chk("snap cmd miso", r, 8'h00);
        r1 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            spi_bit(1'b0, b);
            r1 = {r1[6:0], b};
        end
        load_samples(16'hFFFF, 16'h5678, 16'h9ABC, 8'h19);
        for (int i = 0; i < 4; i++) begin
            spi_bit(1'b0, b);
            r1 = {r1[6:0], b};
        end
        spi_byte(8'h00, r2);
        cs_high();
        chk("snap byte1 X_L", r1, 8'h34);
`ifdef GYRO_RESP_SNAPSHOT_EN
        chk("snap byte2 X_H", r2, 8'h12);
`else
        chk("snap byte2 X_H", r2, 8'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
